apb_master_arb: RTL
===================

APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameter: ADDR_W, 32, address width of requester ports and PADDR.
REQ-002 Parameter: DATA_W, 32, data width of wdata/rdata/PWDATA/PRDATA.
REQ-003 Parameter: SEL_BIT, 4, PADDR bit that selects slave (0 -> PSEL1, 1 -> PSEL2).
REQ-004 Parameter: TIMEOUT, 15, maximum ACCESS cycles without PREADY before abort.
REQ-005 PCLK  input  1  single clock; all state changes on rising edge.
REQ-006 PRESETn  input  1  asynchronous, active-low reset.
REQ-007 req0 / req1  input  1  transaction request from requester 0 / 1; held high until matching done.
REQ-008 we0 / we1  input  1  1 = write, 0 = read, per requester.
REQ-009 addr0 / addr1  input  ADDR_W  target address, per requester.
REQ-010 wdata0 / wdata1  input  DATA_W  write data, per requester.
REQ-011 done0 / done1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-012 rdata  output  DATA_W  read data of last completed transaction.
REQ-013 err  output  1  valid with done pulse; 1 = timed out.
REQ-014 PSEL1 / PSEL2  output  1  APB slave selects.
REQ-015 PENABLE, PWRITE  output  1  APB enable and direction.
REQ-016 PADDR  output  ADDR_W; PWDATA  output  DATA_W  APB address and write data.
REQ-017 PRDATA1 / PRDATA2  input  DATA_W  read data from slave 1 / 2.
REQ-018 PREADY  input  1  completion from selected slave.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, ACCESS; IDLE->SETUP when any req high; SETUP->ACCESS unconditionally after one cycle; ACCESS->IDLE on PREADY or timeout.
REQ-020 Arbitration in IDLE SHALL be round-robin: single requester wins; both requesting -> requester not granted last; after reset requester 0 has priority.
REQ-021 On IDLE->SETUP the granted requester's we/addr/wdata SHALL be latched into PWRITE/PADDR/PWDATA and held constant through ACCESS; later requester input changes ignored.
REQ-022 SETUP: selected PSELx=1, PENABLE=0; ACCESS: PSELx=1, PENABLE=1; IDLE: both PSEL and PENABLE=0.
REQ-023 Exactly one PSEL SHALL be high outside IDLE, chosen by latched PADDR[SEL_BIT].
REQ-024 PREADY SHALL be ignored in IDLE and SETUP.
REQ-025 ACCESS with PREADY=1: on that edge, for reads rdata <= PRDATA of selected slave (writes leave rdata unchanged), err <= 0, granted done pulses high for the following cycle, FSM -> IDLE.
REQ-026 A 4-bit-or-wider wait counter SHALL clear on SETUP and increment each ACCESS cycle with PREADY=0; at TIMEOUT counts: done pulse with err=1, rdata unchanged, FSM -> IDLE, PSEL/PENABLE deassert.
REQ-027 Minimum transaction: SETUP, ACCESS, done; total 3 cycles from req to done with zero-wait slave; each wait state adds one cycle.
REQ-028 FSM SHALL spend at least one cycle in IDLE between transactions (done cycle); requester deasserting req during its done cycle is not re-granted.
REQ-029 A requester dropping req mid-transaction SHALL NOT abort it; done still pulses.
REQ-030 done0 and done1 SHALL never be high in the same cycle; err SHALL hold its value until next done.

Reset
REQ-031 PRESETn low SHALL immediately force IDLE and zero PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rdata, err, done0, done1, wait counter; round-robin pointer -> requester 0 priority.
REQ-032 Reset during SETUP/ACCESS SHALL abandon the transaction with no done pulse; first grant after release follows REQ-020.

Verification
REQ-033 req0 read addr 0x3, slave1 PREADY one cycle into ACCESS, PRDATA1=15 -> PSEL1 SETUP then ACCESS 2 cycles, done0 pulse, rdata=15, err=0.
REQ-034 req1 write addr 0x12 data 0xA5 -> PSEL2=1, PWRITE=1, PADDR=0x12, PWDATA=0xA5 stable SETUP through ACCESS; done1 pulse; rdata unchanged.
REQ-035 req0 and req1 high together continuously -> grants alternate 0,1,0,1; never both done same cycle.
REQ-036 PREADY held low -> after 15 ACCESS cycles done pulse with err=1, PSEL/PENABLE low next cycle; next transaction err=0.
REQ-037 PRESETn low mid-ACCESS -> all outputs 0 asynchronously, no done; after release req1 alone granted normally.

Source files
------------

// File: rtl/apb_master_arb_if.sv
// ============================================================================
// Module      : apb_master_arb_if
// Description : APB bus bundle between the two-requester arbiter and its slaves
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_master_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              PSEL1;
  logic              PSEL2;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA1;
  logic [DATA_W-1:0] PRDATA2;
  logic              PREADY;

  modport master (
    output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA1, PRDATA2, PREADY
  );

  modport slave (
    input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA1, PRDATA2, PREADY
  );
endinterface

`default_nettype wire

// File: rtl/apb_master_arb.sv
// ============================================================================
// Module      : apb_master_arb
// Description : Round-robin arbiter for two requesters onto one APB master
//               port, with two-slave decode and ACCESS-phase timeout
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_BIT = 4,
  parameter int TIMEOUT = 15
) (
  input  wire logic              PCLK,
  input  wire logic              PRESETn,
  input  wire logic              req0,
  input  wire logic              req1,
  input  wire logic              we0,
  input  wire logic              we1,
  input  wire logic [ADDR_W-1:0] addr0,
  input  wire logic [ADDR_W-1:0] addr1,
  input  wire logic [DATA_W-1:0] wdata0,
  input  wire logic [DATA_W-1:0] wdata1,
  output logic                   done0,
  output logic                   done1,
  output logic      [DATA_W-1:0] rdata,
  output logic                   err,
  apb_master_arb_if.master       apb
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_owner;     // requester of the current / most recent grant
  logic [CNT_W-1:0] r_wait_cnt;

  logic              w_grant;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // Both requesting: the one not served last wins; reset leaves r_owner=1 so 0 goes first.
  always_comb begin
    w_grant = 1'b0;
    if (req0 && req1) w_grant = ~r_owner;
    else              w_grant = ~req0;
    w_we    = w_grant ? we1    : we0;
    w_addr  = w_grant ? addr1  : addr0;
    w_wdata = w_grant ? wdata1 : wdata0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b1;
      r_wait_cnt  <= '0;
      apb.PSEL1   <= 1'b0;
      apb.PSEL2   <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      rdata       <= '0;
      err         <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_state    <= S_SETUP;
            r_owner    <= w_grant;
            apb.PWRITE <= w_we;
            apb.PADDR  <= w_addr;
            apb.PWDATA <= w_wdata;
            apb.PSEL1  <= ~w_addr[SEL_BIT];
            apb.PSEL2  <= w_addr[SEL_BIT];
          end
        end
        S_SETUP: begin
          r_state     <= S_ACCESS;
          r_wait_cnt  <= '0;
          apb.PENABLE <= 1'b1;
        end
        S_ACCESS: begin
          if (apb.PREADY || (r_wait_cnt == c_wait_last)) begin
            r_state     <= S_IDLE;
            apb.PSEL1   <= 1'b0;
            apb.PSEL2   <= 1'b0;
            apb.PENABLE <= 1'b0;
            done0       <= ~r_owner;
            done1       <= r_owner;
            err         <= ~apb.PREADY;
            if (apb.PREADY && !apb.PWRITE)
              rdata <= apb.PADDR[SEL_BIT] ? apb.PRDATA2 : apb.PRDATA1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
